// File: rtl/async_fifo_pkg.sv
`default_nettype none
// Shared definitions for the async FIFO and its read-side packer.
package async_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_PACK_RATIO = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } pack_state_t;

endpackage
`default_nettype wire

// File: rtl/async_fifo_rd_packer.sv
`default_nettype none
// Read-side FIFO consumer: packs PACK_RATIO entries into one wide word (lane 0 first)
// and emits it on a valid/ready stream; a flush forces out a partial word.
module async_fifo_rd_packer
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK_RATIO = DEFAULT_PACK_RATIO,
  parameter int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             flush,
  output logic                             flush_done,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [CNT_WIDTH-1:0]             m_cnt,
  output logic                             m_last
);

  localparam int                   OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(PACK_RATIO);
  localparam logic [CNT_WIDTH:0]   FULL_EFF  = (CNT_WIDTH + 1)'(PACK_RATIO);

  pack_state_t           state;
  pack_state_t           state_nxt;
  logic [DATA_WIDTH-1:0] acc [PACK_RATIO];
  logic [CNT_WIDTH-1:0]  acc_cnt;
  logic [CNT_WIDTH-1:0]  eff_base;
  logic [CNT_WIDTH:0]    eff;
  logic                  pend;
  logic                  xfer;
  logic [OUT_WIDTH-1:0]  packed_word;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Pop credit counts entries already held plus the one in flight, so acc never overflows.
  always_comb begin
    state_nxt  = state;
    xfer       = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_RUN:  xfer = (acc_cnt == FULL_CNT) && (!m_valid || m_ready);
      ST_EMIT: xfer = (acc_cnt != '0) && (!m_valid || m_ready);
      default: xfer = 1'b0;
    endcase
    eff_base   = xfer ? '0 : acc_cnt;
    eff        = {1'b0, eff_base} + (CNT_WIDTH + 1)'(pend);
    fifo_rd_en = !rd_rst && (state == ST_RUN) && !flush && !fifo_empty && (eff < FULL_EFF);
    case (state)
      ST_RUN: begin
        if (flush) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pend) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (xfer || (acc_cnt == '0)) begin
          state_nxt  = ST_RUN;
          flush_done = !rd_rst;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (CNT_WIDTH'(i) < acc_cnt) packed_word[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
    end
  end

  always_ff @(posedge rd_clk) begin
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (pend && (acc_cnt == CNT_WIDTH'(i))) acc[i] <= fifo_rd_data;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pend    <= 1'b0;
      acc_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_cnt   <= '0;
      m_last  <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
      if (xfer) begin
        acc_cnt <= '0;
        m_valid <= 1'b1;
        m_data  <= packed_word;
        m_cnt   <= acc_cnt;
        m_last  <= (state == ST_EMIT);
      end else begin
        if (pend)               acc_cnt <= acc_cnt + CNT_WIDTH'(1);
        if (m_valid && m_ready) m_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_packer.sv
`default_nettype none
// Scoreboard bench: a queue-backed FIFO feeds the packer; expected words come from
// grouping pushed entries in fours (partial group on flush).
module tb_async_fifo_rd_packer;

  localparam int DW = 4;
  localparam int PR = 4;
  localparam int CW = $clog2(PR + 1);
  localparam int OW = DW * PR;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] cnt;
    logic          last;
  } word_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [OW-1:0] m_data;
  logic [CW-1:0] m_cnt;
  logic          m_last;

  async_fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .flush_done(flush_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_cnt(m_cnt), .m_last(m_last)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] pending[$];
  word_t         expq[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            pop_count = 0;
  int            fd_count = 0;
  logic [2:0]    fd_hist = '0;
  bit            toggle_mode = 1'b0;
  bit            toggle_ph = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_empty();
    fifo_empty = (fq.size() == 0) || (toggle_mode && toggle_ph);
  endtask

  task automatic emit(input bit last);
    word_t w;
    w.data = '0;
    foreach (pending[i]) w.data |= OW'(pending[i]) << (DW * i);
    w.cnt  = CW'(pending.size());
    w.last = last;
    expq.push_back(w);
    pending.delete();
  endtask

  // hold=1 keeps a completed group back so a flush claims it.
  task automatic model_push(input logic [DW-1:0] v, input bit hold);
    fq.push_back(v);
    pending.push_back(v);
    if (!hold && pending.size() == PR) emit(1'b0);
    update_empty();
  endtask

  task automatic model_flush();
    if (pending.size() > 0) emit(1'b1);
  endtask

  task automatic step();
    bit popped;
    @(negedge rd_clk);
    popped = fifo_rd_en;
    check(!(fifo_rd_en && fifo_empty), "pop_while_empty", fifo_rd_en, 0);
    fd_hist = {fd_hist[1:0], flush_done};
    if (flush_done) fd_count++;
    @(posedge rd_clk);
    #1;
    if (popped) begin
      pop_count++;
      if (fq.size() > 0) fifo_rd_data = fq.pop_front();
    end
    toggle_ph = ~toggle_ph;
    update_empty();
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((fq.size() != 0 || expq.size() != 0) && c < maxc) begin
      step();
      c++;
    end
    check(c < maxc, "drain_timeout", 64'(c), 64'(maxc));
    repeat (4) step();
  endtask

  task automatic do_flush();
    int f0 = fd_count;
    int c = 0;
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    while (fd_count == f0 && c < 30) begin
      step();
      c++;
    end
    repeat (3) step();
    check(fd_count == f0 + 1, "flush_done_pulses", 64'(fd_count - f0), 1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({m_valid, m_data, m_cnt, m_last, flush_done, fifo_rd_en} == '0, name,
          {m_valid, m_data, m_cnt, m_last, flush_done, fifo_rd_en}, 0);
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  initial begin
    word_t e;
    forever begin
      @(negedge rd_clk);
      if (m_valid && m_ready && !rd_rst) begin
        if (expq.size() == 0) begin
          check(1'b0, "unexpected_word", {m_data, m_cnt, m_last}, 0);
        end else begin
          e = expq.pop_front();
          check({m_data, m_cnt, m_last} == e, "word", {m_data, m_cnt, m_last}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int f0;
    // Reset state
    repeat (2) step();
    check_zero_outputs("reset_state");
    rd_rst = 1'b0;
    m_ready = 1'b1;

    // Two straight words
    for (int v = 1; v <= 8; v++) model_push(DW'(v), 1'b0);
    wait_idle(100);

    // Backpressure: only two words' worth of entries may be absorbed
    m_ready = 1'b0;
    p0 = pop_count;
    for (int v = 1; v <= 12; v++) model_push(DW'(v), 1'b0);
    repeat (30) step();
    check(pop_count - p0 == 8, "bp_pop_count", 64'(pop_count - p0), 8);
    check(m_valid && m_data == 16'h4321, "bp_held_word", {m_valid, m_data}, {1'b1, 16'h4321});
    m_ready = 1'b1;
    wait_idle(100);

    // Partial flush then a normal word
    for (int v = 10; v <= 12; v++) model_push(DW'(v), 1'b0);
    wait_idle(100);
    do_flush();
    for (int v = 1; v <= 4; v++) model_push(DW'(v), 1'b0);
    wait_idle(100);

    // Flush with nothing held: done exactly two cycles later, no word
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    check(fd_hist == 3'b001, "empty_flush_timing", fd_hist, 3'b001);
    repeat (4) step();

    // Flush while acc is full and the output register is blocked
    m_ready = 1'b0;
    f0 = fd_count;
    for (int v = 1; v <= 8; v++) model_push(DW'(v), v > 4);
    repeat (16) step();
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    repeat (5) step();
    check(fd_count == f0, "flush_blocked_no_done", 64'(fd_count - f0), 0);
    m_ready = 1'b1;
    wait_idle(100);
    check(fd_count == f0 + 1, "flush_full_done", 64'(fd_count - f0), 1);

    // Reset mid-word discards held entries
    fq.push_back(4'h1);
    fq.push_back(4'h2);
    update_empty();
    repeat (6) step();
    rd_rst = 1'b1;
    fq.delete();
    update_empty();
    step();
    check_zero_outputs("mid_word_reset");
    rd_rst = 1'b0;
    for (int v = 5; v <= 8; v++) model_push(DW'(v), 1'b0);
    wait_idle(100);

    // FIFO empty toggling every cycle
    toggle_mode = 1'b1;
    for (int v = 0; v <= 15; v++) model_push(DW'(v), 1'b0);
    wait_idle(200);
    toggle_mode = 1'b0;
    update_empty();

    // Randomized traffic with random backpressure and occasional flushes
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(2) == 0) model_push(DW'($urandom), 1'b0);
        toggle_mode = ($urandom_range(3) == 0);
        m_ready = ($urandom_range(3) != 0);
        step();
      end
      toggle_mode = 1'b0;
      m_ready = 1'b1;
      update_empty();
      wait_idle(300);
      if (r % 2 == 1) begin
        do_flush();
        wait_idle(100);
      end
    end
    do_flush();
    wait_idle(100);
    check(expq.size() == 0, "scoreboard_empty", 64'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
